// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and command table for the PS/2 mouse init sequencer.
// Build with PS2_SAMPLE_RATE_EN defined to insert the sample-rate steps (0xF3, 0xC8).
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RATE     = 8'hF3;
  localparam logic [7:0] CMD_RATE_VAL = 8'hC8;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_ID     = 8'h00;

  localparam logic [10:0] IDLE_FRAME = 11'h7FF;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_SEND      = 4'd2,
    S_WAIT_OK   = 4'd3,
    S_WAIT_RESP = 4'd4,
    S_RETRY     = 4'd5,
    S_NEXT      = 4'd6
  } state_t;

`ifdef PS2_SAMPLE_RATE_EN
  localparam int NUM_STEPS = 5;
`else
  localparam int NUM_STEPS = 3;
`endif

  function automatic logic [7:0] cmd_of(input logic [2:0] s);
    logic [7:0] c;
    case (s)
      3'd0:    c = CMD_RESET;
      3'd1:    c = CMD_DEFAULTS;
`ifdef PS2_SAMPLE_RATE_EN
      3'd2:    c = CMD_RATE;
      3'd3:    c = CMD_RATE_VAL;
`endif
      default: c = CMD_ENABLE;
    endcase
    return c;
  endfunction

  // Only the reset command answers with more than the ACK.
  function automatic logic [1:0] resp_len(input logic [2:0] s);
    return (s == 3'd0) ? 2'd3 : 2'd1;
  endfunction

  function automatic logic [7:0] resp_of(input logic [2:0] s,
                                         input logic [1:0] idx);
    logic [7:0] r;
    if (s != 3'd0) begin
      r = RSP_ACK;
    end else begin
      case (idx)
        2'd0:    r = RSP_ACK;
        2'd1:    r = RSP_BAT;
        default: r = RSP_ID;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_mouse_init_seq_frame_build.sv
// Combinational byte to 11-bit host-to-device frame:
// start 0, data LSB first, odd parity, stop 1.
module ps2_frame_build (
  input  logic [7:0]  data,
  output logic [0:10] frame
);

  always_comb begin
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      frame[1+i] = data[i];
    end
    frame[9]  = ~^data;
    frame[10] = 1'b1;
  end

endmodule

// File: rtl/ps2_mouse_init_seq.sv
// Sequencer bringing a PS/2 mouse into streaming mode via the host sender.
// Build with PS2_SAMPLE_RATE_EN defined for the 5-step sample-rate variant.
module ps2_mouse_init_seq
  import ps2_pkg::*;
#(
  parameter logic [29:0] TIMEOUT_CYC = 30'd50_000_000,
  parameter logic [15:0] SEND_HOLD   = 16'd400,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tx_ok,
  input  logic        tx_err,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [0:10] frame,
  output logic        send,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [2:0]  step,
  output logic [3:0]  status
);

  localparam logic [3:0] MAX_R     = 4'(MAX_RETRY);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  state_t      state, state_n;
  logic [2:0]  step_n;
  logic [3:0]  retry, retry_n;
  logic [1:0]  idx, idx_n;
  logic [0:10] frame_n;
  logic [15:0] hold_cnt, hold_n;
  logic [29:0] tmo, tmo_n;
  logic        done_n, fail_n;
  logic        tmo_exp;
  logic [0:10] cmd_frame;

  ps2_frame_build u_build (
    .data  (cmd_of(step)),
    .frame (cmd_frame)
  );

  assign send   = (state == S_SEND);
  assign busy   = (state != S_IDLE);
  assign status = state;
  assign tmo_exp = (tmo == TIMEOUT_CYC - 30'd1);

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      step     <= '0;
      retry    <= '0;
      idx      <= '0;
      frame    <= IDLE_FRAME;
      hold_cnt <= '0;
      tmo      <= '0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      retry    <= retry_n;
      idx      <= idx_n;
      frame    <= frame_n;
      hold_cnt <= hold_n;
      tmo      <= tmo_n;
      done     <= done_n;
      fail     <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    retry_n = retry;
    idx_n   = idx;
    frame_n = frame;
    hold_n  = hold_cnt;
    tmo_n   = tmo;
    done_n  = done;
    fail_n  = fail;
    // Outside SEND, hold_cnt measures how long send has been low.
    if (state != S_SEND && hold_cnt != 16'hFFFF) begin
      hold_n = hold_cnt + 16'd1;
    end
    if (state == S_WAIT_OK || state == S_WAIT_RESP) begin
      tmo_n = tmo + 30'd1;
    end
    unique case (state)
      S_IDLE: begin
        if (start) begin
          done_n  = 1'b0;
          fail_n  = 1'b0;
          step_n  = '0;
          retry_n = '0;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        frame_n = cmd_frame;
        idx_n   = '0;
        hold_n  = '0;
        state_n = S_SEND;
      end
      S_SEND: begin
        hold_n = hold_cnt + 16'd1;
        if (hold_cnt == SEND_HOLD - 16'd1) begin
          hold_n  = '0;
          tmo_n   = '0;
          state_n = S_WAIT_OK;
        end
      end
      S_WAIT_OK: begin
        if (tx_ok) begin
          if (tx_err) begin
            state_n = S_RETRY;
          end else begin
            tmo_n   = '0;
            state_n = S_WAIT_RESP;
          end
        end else if (tmo_exp) begin
          state_n = S_RETRY;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid) begin
          if (rx_data == resp_of(step, idx)) begin
            tmo_n = '0;
            if (idx == resp_len(step) - 2'd1) begin
              state_n = S_NEXT;
            end else begin
              idx_n = idx + 2'd1;
            end
          end else begin
            state_n = S_RETRY;
          end
        end else if (tmo_exp) begin
          state_n = S_RETRY;
        end
      end
      S_RETRY: begin
        // The sender only re-triggers on a fresh rising edge.
        if (hold_cnt >= SEND_HOLD) begin
          if (retry < MAX_R) begin
            retry_n = retry + 4'd1;
            state_n = S_LOAD;
          end else begin
            fail_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_NEXT: begin
        if (step == LAST_STEP) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          step_n  = step + 3'd1;
          retry_n = '0;
          state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Randomized bench for ps2_mouse_init_seq with a device model and
// an expected-command-list reference.
module tb_ps2_mouse_init_seq;

  localparam logic [15:0] HOLD = 16'd400;
`ifdef PS2_SAMPLE_RATE_EN
  localparam int NCMD = 5;
`else
  localparam int NCMD = 3;
`endif

  logic        clk = 1'b0;
  logic        reset, start, tx_ok, tx_err, rx_valid;
  logic [7:0]  rx_data;
  logic [0:10] frame;
  logic        send, busy, done, fail;
  logic [2:0]  step;
  logic [3:0]  status;
  logic [10:0] frame_pk;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] fr_q[$];
  int          hi_q[$];
  int          gap_q[$];

  logic       err_ff = 1'b0;
  logic [7:0] nak_cmd = 8'h00;
  logic [7:0] nak_byte = 8'hFE;
  int         nak_left = 0;
  logic [7:0] silent_cmd = 8'h00;
  int         silent_left = 0;

  always #5 clk = ~clk;

  ps2_mouse_init_seq #(
    .TIMEOUT_CYC (30'd1000),
    .SEND_HOLD   (HOLD),
    .MAX_RETRY   (3)
  ) dut (
    .qzt_clk  (clk),
    .reset    (reset),
    .start    (start),
    .tx_ok    (tx_ok),
    .tx_err   (tx_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame    (frame),
    .send     (send),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .step     (step),
    .status   (status)
  );

  always_comb begin
    frame_pk = '0;
    for (int i = 0; i < 11; i++) frame_pk[i] = frame[i];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  function automatic logic [7:0] base_cmd(input int k);
    logic [7:0] l[$];
`ifdef PS2_SAMPLE_RATE_EN
    l = '{8'hFF, 8'hF6, 8'hF3, 8'hC8, 8'hF4};
`else
    l = '{8'hFF, 8'hF6, 8'hF4};
`endif
    return l[k];
  endfunction

  // Expected sends: every command once, the one at index k repeated c times.
  task automatic build_exp(input int k, input int c);
    exp_q.delete();
    for (int i = 0; i < NCMD; i++) begin
      exp_q.push_back(base_cmd(i));
      if (i == k) for (int j = 0; j < c; j++) exp_q.push_back(base_cmd(i));
    end
  endtask

  // Send monitor: frame at each rising edge, high length, preceding low length.
  logic     send_prev = 1'b0;
  int       hi_cnt = 0;
  int       low_cnt = 100000;
  always @(negedge clk) begin
    if (send && !send_prev) begin
      fr_q.push_back(frame_pk);
      gap_q.push_back(low_cnt);
      hi_cnt = 1;
    end else if (send) begin
      hi_cnt++;
    end
    if (!send && send_prev) hi_q.push_back(hi_cnt);
    low_cnt = send ? 0 : low_cnt + 1;
    send_prev = send;
  end

  task automatic serve();
    int g, t;
    logic [7:0] cmd;
    logic e;
    logic [7:0] rsp[$];
    forever begin
      g = 0;
      while (!send && busy && g < 5000) begin @(negedge clk); g++; end
      if (!busy) return;
      if (g >= 5000) begin chk("wait_send", 0, 1); return; end
      for (int i = 0; i < 8; i++) cmd[i] = frame[1+i];
      // Stray byte and start while sending must be ignored.
      @(negedge clk);
      rx_data = 8'hFA; rx_valid = 1'b1; start = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0; start = 1'b0;
      g = 0;
      while (send && g < 1000) begin @(negedge clk); g++; end
      if (g >= 1000) begin chk("send_stuck", 1, 0); return; end
      repeat ($urandom_range(1, 20)) @(negedge clk);
      e = err_ff && (cmd == 8'hFF);
      tx_ok = 1'b1; tx_err = e;
      @(negedge clk);
      tx_ok = 1'b0; tx_err = 1'b0;
      if (e) continue;
      if (cmd == silent_cmd && silent_left > 0) begin
        silent_left--;
        t = 0;
        while (!send && t < 3000) begin @(negedge clk); t++; end
        chk("tmo_resend", 32'((t >= 1000) && (t <= 1010)), 1);
        continue;
      end
      if (cmd == 8'hFF) rsp = '{8'hFA, 8'hAA, 8'h00};
      else rsp = '{8'hFA};
      if (cmd == nak_cmd && nak_left > 0) begin
        nak_left--;
        rsp = '{nak_byte};
      end
      foreach (rsp[i]) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        rx_data = rsp[i]; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'($urandom);
      end
    end
  endtask

  task automatic run(input string tag, input logic exp_done);
    int n;
    fr_q.delete(); hi_q.delete(); gap_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    serve();
    chk({tag, "_nsends"}, fr_q.size(), exp_q.size());
    n = (fr_q.size() < exp_q.size()) ? fr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_frame%0d", tag, i), 32'(fr_q[i]), 32'(exp_frame(exp_q[i])));
      if (i < hi_q.size())
        chk($sformatf("%s_hold%0d", tag, i), hi_q[i], 32'(HOLD));
      if (i > 0 && exp_q[i] == exp_q[i-1])
        chk($sformatf("%s_gap%0d", tag, i), 32'(gap_q[i] >= int'(HOLD)), 1);
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_fail"}, 32'(fail), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(busy), 0);
    if (exp_done) chk({tag, "_step"}, 32'(step), NCMD - 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c;
    reset = 1'b1; start = 1'b0; tx_ok = 1'b0; tx_err = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_frame", 32'(frame_pk), 32'h7FF);
    chk("rst_send", 32'(send), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_status", 32'(status), 0);
    reset = 1'b0;

    build_exp(-1, 0);
    run("nom", 1'b1);

    nak_cmd = 8'hF6; nak_byte = 8'hFE; nak_left = 1;
    build_exp(1, 1);
    run("nak", 1'b1);

    err_ff = 1'b1;
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run("err", 1'b0);
    err_ff = 1'b0;

    silent_cmd = 8'hF4; silent_left = 1;
    build_exp(NCMD - 1, 1);
    run("tmo", 1'b1);

    // Reset while send is high.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!send && k < 100) begin @(negedge clk); k++; end
    chk("mid_send_seen", 32'(send), 1);
    repeat (50) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_send", 32'(send), 0);
    chk("mid_frame", 32'(frame_pk), 32'h7FF);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_status", 32'(status), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_no_restart", 32'(busy), 0);
    build_exp(-1, 0);
    run("restart", 1'b1);

    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(0, NCMD - 1);
      c = $urandom_range(0, 3);
      nak_cmd = base_cmd(k);
      nak_byte = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h55;
      nak_left = c;
      build_exp(k, c);
      run($sformatf("rnd%0d", r), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
